// File: rtl/mul4x4_seq_ctrl.sv
// rtl/mul4x4_seq_ctrl.sv - 4x4 unsigned multiplier sequenced over a shared 2x2 multiplier cell
module mul4x4_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [1:0] mul_x,
    output logic [1:0] mul_y,
    input  logic [3:0] mul_p,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] k;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] acc;
    logic [1:0] half_sum;
    logic [7:0] term;

    // k[0] selects the half of ra, k[1] the half of rb.
    always_comb begin
        mul_x = 2'b00;
        mul_y = 2'b00;
        if (state == RUN) begin
            mul_x = k[0] ? ra[3:2] : ra[1:0];
            mul_y = k[1] ? rb[3:2] : rb[1:0];
        end
    end

    // Partial product weight is 2*(k[0]+k[1]): 0, 2, 2 or 4.
    assign half_sum = {k[0] & k[1], k[0] ^ k[1]};
    assign term     = {4'b0000, mul_p} << {half_sum, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= 2'd0;
            ra    <= 4'd0;
            rb    <= 4'd0;
            acc   <= 8'd0;
            p     <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        acc   <= 8'd0;
                        k     <= 2'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (k == 2'd3) begin
                        p     <= acc + term;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        acc <= acc + term;
                        k   <= k + 2'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul4x4_seq_ctrl.sv
// tb/tb_mul4x4_seq_ctrl.sv - directed self-checking bench for mul4x4_seq_ctrl
module tb_mul4x4_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] mul_x;
    logic [1:0] mul_y;
    logic [3:0] mul_p;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External shared 2x2 cell
    assign mul_p = {2'b00, mul_x} * {2'b00, mul_y};

    mul4x4_seq_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .mul_x (mul_x),
        .mul_y (mul_y),
        .mul_p (mul_p),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    // Starts one operation; lat counts negedges from start drive to done (5 expected), 99 on timeout.
    task automatic do_mul(input logic [3:0] ta, input logic [3:0] tb_v,
                          output logic [7:0] pr, output int lat);
        int i;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        lat = 99; pr = 8'd0; i = 0;
        while (lat == 99 && i < 10) begin
            @(negedge clk);
            start = 1'b0;
            i++;
            if (done) begin
                lat = i;
                pr  = p;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; a = 4'd15; b = 4'd15;
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (p !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || mul_x !== 2'd0 || mul_y !== 2'd0) begin
            failures++;
            $display("FAIL reset: p=%0d busy=%b done=%b mul_x=%0d mul_y=%0d, want 0 0 0 0 0",
                     p, busy, done, mul_x, mul_y);
        end
    endtask

    task automatic test_basic;
        logic [1:0] exp_x [4];
        logic [1:0] exp_y [4];
        exp_x = '{2'd3, 2'd2, 2'd3, 2'd2};
        exp_y = '{2'd2, 2'd2, 2'd1, 2'd1};
        @(negedge clk);
        a = 4'd11; b = 4'd6; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || mul_x !== exp_x[i] || mul_y !== exp_y[i]) begin
                failures++;
                $display("FAIL basic_step%0d: busy=%b done=%b x=%0d y=%0d, want busy=1 done=0 x=%0d y=%0d",
                         i, busy, done, mul_x, mul_y, exp_x[i], exp_y[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || p !== 8'd66) begin
            failures++;
            $display("FAIL basic_done: done=%b busy=%b p=%0d, want done=1 busy=0 p=66", done, busy, p);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || p !== 8'd66 || mul_x !== 2'd0) begin
            failures++;
            $display("FAIL basic_after: done=%b p=%0d mul_x=%0d, want done=0 p=66 mul_x=0", done, p, mul_x);
        end
    endtask

    task automatic test_corners;
        logic [7:0] r;
        int lat;
        do_mul(4'd15, 4'd15, r, lat);
        checks++;
        if (r !== 8'd225 || lat != 5) begin
            failures++;
            $display("FAIL max: p=%0d lat=%0d, want p=225 lat=5", r, lat);
        end
        do_mul(4'd0, 4'd9, r, lat);
        checks++;
        if (r !== 8'd0 || lat != 5) begin
            failures++;
            $display("FAIL zero: p=%0d lat=%0d, want p=0 lat=5", r, lat);
        end
    endtask

    task automatic test_exhaustive;
        logic [7:0] r;
        logic [7:0] want;
        int lat;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                want = 8'(x * y);
                do_mul(4'(x), 4'(y), r, lat);
                checks++;
                if (r !== want || lat != 5) begin
                    failures++;
                    $display("FAIL exh %0dx%0d: p=%0d lat=%0d, want p=%0d lat=5", x, y, r, lat, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        a = 4'd3; b = 4'd5; start = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1 || p !== 8'd15) begin
            failures++;
            $display("FAIL b2b_first: done=%b p=%0d, want done=1 p=15", done, p);
        end
        a = 4'd7; b = 4'd7;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_noidle: busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        repeat (4) @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || p !== 8'd49) begin
            failures++;
            $display("FAIL b2b_second: done=%b p=%0d, want done=1 p=49", done, p);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore;
        @(negedge clk);
        a = 4'd9; b = 4'd13; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
            a = 4'(15 - i); b = 4'(i + 2);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || p !== 8'd117) begin
            failures++;
            $display("FAIL ignore: done=%b p=%0d, want done=1 p=117", done, p);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen_done;
        @(negedge clk);
        a = 4'd13; b = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mul_x !== 2'd1 || mul_y !== 2'd2) begin
            failures++;
            $display("FAIL rmid_k2: busy=%b x=%0d y=%0d, want busy=1 x=1 y=2", busy, mul_x, mul_y);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 8'd0 || mul_x !== 2'd0) begin
            failures++;
            $display("FAIL rmid_abort: busy=%b done=%b p=%0d x=%0d, want 0 0 0 0", busy, done, p, mul_x);
        end
        rst = 1'b0; a = 4'd5; b = 4'd6; start = 1'b1;
        lat = 99; seen_done = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && !seen_done) begin
                seen_done = 1'b1;
                lat = i;
                checks++;
                if (p !== 8'd30) begin
                    failures++;
                    $display("FAIL rmid_restart: p=%0d, want 30", p);
                end
            end
        end
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL rmid_latency: lat=%0d, want 5", lat);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
        test_reset;
        test_basic;
        test_corners;
        test_exhaustive;
        test_back_to_back;
        test_ignore;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
